// File: rtl/modport_counter.sv
// ---------------------------------------------------------------------------
// modport_counter
//
// Purpose:
//   WIDTH-bit synchronous up/down counter with enable, parallel load, a
//   terminal-count flag and a compare (match) flag. The visible count is
//   masked to zero combinationally while reset is high, so the count reads
//   zero at every edge where reset is sampled high, including the very first.
//
// Update priority on each rising clk edge (highest first):
//   reset -> clear, load -> d, en & !dir -> +1, en & dir -> -1, else hold.
//   Arithmetic is modulo 2^WIDTH.
//
// Ports:
//   clk    in   1      sole clock, rising edge
//   reset  in   1      synchronous, active-high reset
//   en     in   1      count enable
//   dir    in   1      count direction: 0 = up, 1 = down
//   load   in   1      parallel-load strobe
//   d      in   WIDTH  parallel-load value
//   c      out  WIDTH  current count (0 while reset is high)
//   tc     out  1      terminal count: all-ones counting up, zero counting down
//   match  out  1      c == MATCH
// ---------------------------------------------------------------------------
module modport_counter #(
    parameter int WIDTH = 3,
    parameter int MATCH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] c,
    output logic             tc,
    output logic             match
);

    localparam logic [WIDTH-1:0] MATCH_V = WIDTH'(MATCH);
    localparam logic [WIDTH-1:0] MAX_V   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_V   = WIDTH'(1);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next-state for the non-reset cases; reset is handled in the register.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = d;
        end else if (en) begin
            if (dir) begin
                cnt_d = cnt_q - ONE_V;
            end else begin
                cnt_d = cnt_q + ONE_V;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The mask hides the undefined pre-reset register value and makes the
    // count read zero in the same cycle reset is raised.
    always_comb begin
        c = reset ? '0 : cnt_q;
    end

    // tc needs an explicit reset gate: counting down, c == 0 during reset
    // would otherwise raise it. match needs none, since c is already 0 in
    // reset, which yields 1 exactly when MATCH is 0.
    always_comb begin
        tc    = 1'b0;
        match = (c == MATCH_V);
        if (!reset) begin
            tc = dir ? (c == '0) : (c == MAX_V);
        end
    end

endmodule

// File: tb/tb_modport_counter.sv
// ---------------------------------------------------------------------------
// tb_modport_counter
//
// Directed bench for modport_counter with default parameters (WIDTH = 3,
// MATCH = 5). Inputs change 1 ns after a rising edge; outputs are examined
// 1-2 ns after that edge, i.e. the value that the next edge will sample.
// Each check compares the packed triple {c, tc, match}.
// ---------------------------------------------------------------------------
module tb_modport_counter;

    logic       clk;
    logic       reset;
    logic       en;
    logic       dir;
    logic       load;
    logic [2:0] d;
    logic [2:0] c;
    logic       tc;
    logic       match;

    int n_checks;
    int n_fail;

    modport_counter #(
        .WIDTH (3),
        .MATCH (5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .dir   (dir),
        .load  (load),
        .d     (d),
        .c     (c),
        .tc    (tc),
        .match (match)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and step past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One reset edge, then release with counting up enabled.
    task automatic do_reset();
        reset = 1'b1;
        load  = 1'b0;
        en    = 1'b1;
        dir   = 1'b0;
        tick();
        reset = 1'b0;
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        en    = 1'b1;
        dir   = 1'b0;
        load  = 1'b0;
        d     = 3'd0;
        #1;
        // Before any edge: the mask must hold c at 0 despite an undefined register.
        if ({c, tc, match} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL reset_pre_edge: got c/tc/match=%b expected %b", {c, tc, match}, 5'b000_0_0);
        end
        n_checks++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({c, tc, match} !== 5'b000_0_0) begin
                n_fail++;
                $display("FAIL reset_hold_%0d: got c/tc/match=%b expected %b", i, {c, tc, match}, 5'b000_0_0);
            end
            n_checks++;
        end
        // Counting down, c == 0 would raise tc if it were not gated by reset.
        dir = 1'b1;
        #1;
        if ({c, tc, match} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL reset_tc_down: got c/tc/match=%b expected %b", {c, tc, match}, 5'b000_0_0);
        end
        n_checks++;
        tick();
        dir = 1'b0;
    endtask

    // Release from reset and free-run ten samples: 0..7,0,1.
    task automatic test_free_run();
        logic [4:0] exp_tab [10];
        exp_tab = '{5'b000_0_0, 5'b001_0_0, 5'b010_0_0, 5'b011_0_0, 5'b100_0_0,
                    5'b101_0_1, 5'b110_0_0, 5'b111_1_0, 5'b000_0_0, 5'b001_0_0};
        reset = 1'b0;
        #1;
        for (int i = 0; i < 10; i++) begin
            if ({c, tc, match} !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL free_run_%0d: got c/tc/match=%b expected %b", i, {c, tc, match}, exp_tab[i]);
            end
            n_checks++;
            tick();
        end
    endtask

    task automatic test_mid_reset();
        do_reset();
        tick(); tick(); tick();
        if ({c, tc, match} !== 5'b011_0_0) begin
            n_fail++;
            $display("FAIL mid_reset_at3: got c/tc/match=%b expected %b", {c, tc, match}, 5'b011_0_0);
        end
        n_checks++;
        reset = 1'b1;
        #1;
        if ({c, tc, match} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL mid_reset_mask: got c/tc/match=%b expected %b", {c, tc, match}, 5'b000_0_0);
        end
        n_checks++;
        tick();
        reset = 1'b0;
        #1;
        if ({c, tc, match} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL mid_reset_cleared: got c/tc/match=%b expected %b", {c, tc, match}, 5'b000_0_0);
        end
        n_checks++;
        tick();
        if ({c, tc, match} !== 5'b001_0_0) begin
            n_fail++;
            $display("FAIL mid_reset_resume: got c/tc/match=%b expected %b", {c, tc, match}, 5'b001_0_0);
        end
        n_checks++;
    endtask

    task automatic test_load();
        do_reset();
        tick(); tick();
        // en stays high: load must win with no extra increment.
        load = 1'b1;
        d    = 3'd6;
        tick();
        load = 1'b0;
        #1;
        if ({c, tc, match} !== 5'b110_0_0) begin
            n_fail++;
            $display("FAIL load_6: got c/tc/match=%b expected %b", {c, tc, match}, 5'b110_0_0);
        end
        n_checks++;
        tick();
        if ({c, tc, match} !== 5'b111_1_0) begin
            n_fail++;
            $display("FAIL load_then_7: got c/tc/match=%b expected %b", {c, tc, match}, 5'b111_1_0);
        end
        n_checks++;
        tick();
        if ({c, tc, match} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL load_wrap: got c/tc/match=%b expected %b", {c, tc, match}, 5'b000_0_0);
        end
        n_checks++;
        // Reset and load together: reset wins.
        reset = 1'b1;
        load  = 1'b1;
        d     = 3'd6;
        tick();
        reset = 1'b0;
        load  = 1'b0;
        #1;
        if ({c, tc, match} !== 5'b000_0_0) begin
            n_fail++;
            $display("FAIL load_vs_reset: got c/tc/match=%b expected %b", {c, tc, match}, 5'b000_0_0);
        end
        n_checks++;
    endtask

    task automatic test_direction();
        logic [4:0] exp_tab [4];
        exp_tab = '{5'b001_0_0, 5'b000_1_0, 5'b111_0_0, 5'b110_0_0};
        do_reset();
        tick();
        dir = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            if ({c, tc, match} !== exp_tab[i]) begin
                n_fail++;
                $display("FAIL down_%0d: got c/tc/match=%b expected %b", i, {c, tc, match}, exp_tab[i]);
            end
            n_checks++;
            if (i < 3) tick();
        end
        // Turning back up at 6 gives 7 on the very next edge.
        dir = 1'b0;
        tick();
        if ({c, tc, match} !== 5'b111_1_0) begin
            n_fail++;
            $display("FAIL dir_turnaround: got c/tc/match=%b expected %b", {c, tc, match}, 5'b111_1_0);
        end
        n_checks++;
    endtask

    task automatic test_enable();
        do_reset();
        tick(); tick(); tick(); tick();
        if ({c, tc, match} !== 5'b100_0_0) begin
            n_fail++;
            $display("FAIL enable_at4: got c/tc/match=%b expected %b", {c, tc, match}, 5'b100_0_0);
        end
        n_checks++;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if ({c, tc, match} !== 5'b100_0_0) begin
                n_fail++;
                $display("FAIL enable_hold_%0d: got c/tc/match=%b expected %b", i, {c, tc, match}, 5'b100_0_0);
            end
            n_checks++;
        end
        en = 1'b1;
        tick();
        if ({c, tc, match} !== 5'b101_0_1) begin
            n_fail++;
            $display("FAIL enable_resume: got c/tc/match=%b expected %b", {c, tc, match}, 5'b101_0_1);
        end
        n_checks++;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_free_run();
        test_mid_reset();
        test_load();
        test_direction();
        test_enable();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
